// File: rtl/i2s_pkg.sv
// Shared constants and strobe bundle for the CS4272 I2S codec interface.
// The frame counter decodes below assume a 1024-clk LRCLK period.
package i2s_pkg;

    localparam int SAMPLE_W = 24;
    localparam int CNT_W    = 10;

    localparam logic [CNT_W-1:0] RX_LFT_DONE = 10'h187;
    localparam logic [CNT_W-1:0] RX_RHT_DONE = 10'h387;
    localparam logic [CNT_W-1:0] VLD_CNT     = 10'h388;
    localparam logic [CNT_W-1:0] TX_LFT_LD   = 10'h00F;
    localparam logic [CNT_W-1:0] TX_RHT_LD   = 10'h20F;

    localparam logic [4:0] FIRST_SLOT = 5'd1;
    localparam logic [4:0] LAST_SLOT  = 5'd24;

    typedef struct packed {
        logic rx_shift;
        logic rx_lft_done;
        logic rx_rht_done;
        logic vld_set;
        logic tx_lft_ld;
        logic tx_rht_ld;
        logic tx_shift;
        logic tx_end;
        logic wrap;
    } strobe_t;

endpackage

// File: rtl/i2s_clk_gen.sv
// Free-running frame counter, codec clock outputs and decoded per-cycle strobes.
// The clocks are taken straight from counter flops, so they cannot glitch.
module i2s_clk_gen
    import i2s_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    output logic    MCLK,
    output logic    SCLK,
    output logic    LRCLK,
    output strobe_t stb
);

    logic [CNT_W-1:0] cnt;
    logic [4:0]       slot;
    logic             data_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign MCLK  = cnt[1];
    assign SCLK  = cnt[3];
    assign LRCLK = cnt[CNT_W-1];

    assign slot      = cnt[8:4];
    assign data_slot = (slot >= FIRST_SLOT) && (slot <= LAST_SLOT);

    // Phase 7 is the cycle before SCLK rises; phase F is the cycle before it falls.
    always_comb begin
        stb             = '0;
        stb.rx_shift    = (cnt[3:0] == 4'h7) && data_slot;
        stb.rx_lft_done = (cnt == RX_LFT_DONE);
        stb.rx_rht_done = (cnt == RX_RHT_DONE);
        stb.vld_set     = (cnt == VLD_CNT - 10'd1);
        stb.tx_lft_ld   = (cnt == TX_LFT_LD);
        stb.tx_rht_ld   = (cnt == TX_RHT_LD);
        stb.tx_shift    = (cnt[3:0] == 4'hF) && (slot >= FIRST_SLOT) && (slot < LAST_SLOT);
        stb.tx_end      = (cnt[3:0] == 4'hF) && (slot == LAST_SLOT);
        stb.wrap        = (cnt == '1);
    end

endmodule

// File: rtl/i2s_serdes.sv
// Codec-side I2S serializer/deserializer with codec reset sequencing.
// Left is held until the right sample lands so both channels present on one vld.
module i2s_serdes
    import i2s_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SDout,
    input  logic signed [SAMPLE_W-1:0] lft_out,
    input  logic signed [SAMPLE_W-1:0] rht_out,
    output logic                       MCLK,
    output logic                       SCLK,
    output logic                       LRCLK,
    output logic                       SDin,
    output logic                       RSTn,
    output logic signed [SAMPLE_W-1:0] lft_in,
    output logic signed [SAMPLE_W-1:0] rht_in,
    output logic                       vld
);

    strobe_t                    stb;
    logic [SAMPLE_W-2:0]        rx_sh;
    logic signed [SAMPLE_W-1:0] lft_hold;
    logic [SAMPLE_W-2:0]        tx_sh;
    logic [1:0]                 frm_cnt;
    logic                       vld_en;

    function automatic logic signed [SAMPLE_W-1:0] rx_word(input logic [SAMPLE_W-2:0] sh,
                                                           input logic            last_bit);
        return {sh, last_bit};
    endfunction

    i2s_clk_gen u_clk_gen (
        .clk   (clk),
        .rst   (rst),
        .MCLK  (MCLK),
        .SCLK  (SCLK),
        .LRCLK (LRCLK),
        .stb   (stb)
    );

    // Codec held in reset for the first frame, then two settling frames without vld.
    always_ff @(posedge clk) begin
        if (rst) begin
            RSTn    <= 1'b0;
            frm_cnt <= 2'd0;
        end else begin
            if (stb.wrap) begin
                RSTn <= 1'b1;
            end
            if (stb.wrap && RSTn && (frm_cnt != 2'd3)) begin
                frm_cnt <= frm_cnt + 2'd1;
            end
        end
    end

    assign vld_en = frm_cnt[1];

    always_ff @(posedge clk) begin
        if (stb.rx_shift) begin
            rx_sh <= {rx_sh[SAMPLE_W-3:0], SDout};
        end
        if (stb.rx_lft_done) begin
            lft_hold <= rx_word(rx_sh, SDout);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lft_in <= '0;
            rht_in <= '0;
            vld    <= 1'b0;
        end else begin
            vld <= stb.vld_set && vld_en;
            if (stb.rx_rht_done) begin
                rht_in <= rx_word(rx_sh, SDout);
                lft_in <= lft_hold;
            end
        end
    end

    // The MSB goes straight to SDin at load; the shift register keeps the remaining bits.
    always_ff @(posedge clk) begin
        if (stb.tx_lft_ld) begin
            tx_sh <= lft_out[SAMPLE_W-2:0];
        end else if (stb.tx_rht_ld) begin
            tx_sh <= rht_out[SAMPLE_W-2:0];
        end else if (stb.tx_shift) begin
            tx_sh <= {tx_sh[SAMPLE_W-3:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            SDin <= 1'b0;
        end else if (stb.tx_lft_ld) begin
            SDin <= lft_out[SAMPLE_W-1];
        end else if (stb.tx_rht_ld) begin
            SDin <= rht_out[SAMPLE_W-1];
        end else if (stb.tx_shift) begin
            SDin <= tx_sh[SAMPLE_W-2];
        end else if (stb.tx_end) begin
            SDin <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_serdes.sv
// Bench for i2s_serdes: a codec model drives SDout from random frames and a
// scoreboard of expected vld cycles/values is checked by an independent monitor.
module tb_i2s_serdes;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        SDout;
    logic        sd_model = 1'b0;
    logic        loop = 1'b0;
    logic [23:0] lft_out, rht_out, lft_in, rht_in;
    logic        MCLK, SCLK, LRCLK, SDin, RSTn, vld;

    assign SDout = loop ? SDin : sd_model;

    i2s_serdes dut (
        .clk     (clk),
        .rst     (rst),
        .SDout   (SDout),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .MCLK    (MCLK),
        .SCLK    (SCLK),
        .LRCLK   (LRCLK),
        .SDin    (SDin),
        .RSTn    (RSTn),
        .lft_in  (lft_in),
        .rht_in  (rht_in),
        .vld     (vld)
    );

    always #10 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [23:0] l;
        logic [23:0] r;
    } exp_t;

    exp_t        exp_q[$];
    int          t = 0;
    int          epoch = 0;
    int          frame = 0;
    bit          run = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_vld = 0;
    logic [23:0] rx_l = '0, rx_r = '0, tx_l = '0, tx_r = '0;
    logic [23:0] exp_l = '0, exp_r = '0, hold_l = '0, hold_r = '0;

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s t=%0d epoch=%0d: got %h, expected %h", name, t, epoch, act, req);
        end
    endtask

    // I2S wire value at frame position p: one-bit delay, 24 data bits MSB first, then zeros.
    function automatic logic wire_bit(input int p, input logic [23:0] l, input logic [23:0] r);
        int          slot;
        logic [23:0] w;
        slot = (p % 512) / 16;
        w    = (p >= 512) ? r : l;
        if (slot >= 1 && slot <= 24) return w[24 - slot];
        return 1'b0;
    endfunction

    task automatic drive_cycle();
        int p;
        int slot;
        p = t % 1024;
        slot = (p % 512) / 16;
        if (p == 0) begin
            frame = t / 1024;
            tx_l  = lft_out;
            tx_r  = rht_out;
            rx_l  = 24'($urandom);
            rx_r  = 24'($urandom);
            if (epoch == 0 && frame == 3) begin
                rx_l = 24'hA5A5A5;
                rx_r = 24'h5A5A5A;
            end
            loop  = (epoch == 0 && frame >= 8 && frame <= 10);
            exp_l = loop ? tx_l : rx_l;
            exp_r = loop ? tx_r : rx_r;
            if (frame >= 3) exp_q.push_back('{t + 904, exp_l, exp_r});
        end
        if (p % 16 == 0) begin
            if (slot >= 1 && slot <= 24) sd_model = wire_bit(p, rx_l, rx_r);
            else                         sd_model = 1'($urandom);
        end
        if (p == 'h389) begin
            lft_out = 24'($urandom);
            rht_out = 24'($urandom);
            if (epoch == 0 && frame == 8) begin
                lft_out = 24'h123456;
                rht_out = 24'hFEDCBA;
            end
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            int p;
            bit exp_v;
            exp_t e;
            p = t % 1024;
            check("clocks{MCLK,SCLK,LRCLK,RSTn}", 24'({MCLK, SCLK, LRCLK, RSTn}),
                  24'({p[1], p[3], p[9], (t >= 1024)}));
            check("sdin", 24'(SDin), 24'(wire_bit(p, tx_l, tx_r)));
            exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == t);
            check("vld", 24'(vld), 24'(exp_v));
            if (exp_v) begin
                e = exp_q.pop_front();
                if (vld) begin
                    n_vld++;
                    check("vld_lft_in", lft_in, e.l);
                    check("vld_rht_in", rht_in, e.r);
                end
            end
            if (p == 904) begin
                hold_l = exp_l;
                hold_r = exp_r;
            end
            check("lft_in", lft_in, hold_l);
            check("rht_in", rht_in, hold_r);
        end
    end

    initial begin
        lft_out = 24'h800001;
        rht_out = 24'h7FFFFE;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        t   = 0;
        drive_cycle();
        run = 1'b1;
        while (!(epoch == 1 && t >= 6 * 1024 - 1)) begin
            @(posedge clk);
            #1;
            if (rst) begin
                // One-cycle reset has just been taken; the whole startup restarts.
                rst    = 1'b0;
                t      = 0;
                epoch  = 1;
                hold_l = '0;
                hold_r = '0;
                exp_q.delete();
                drive_cycle();
            end else begin
                t++;
                if (epoch == 0 && t == 11 * 1024 + 'h150) rst = 1'b1;
                drive_cycle();
            end
        end
        @(negedge clk);
        #1;
        run = 1'b0;
        check("vld_count", 24'(n_vld), 24'd11);
        check("pending_vld", 24'(exp_q.size()), 24'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
